reg_file_mp: RTL and testbench

Parametrised multi-port register file: the next generation of the 16×8, two-read/one-write `reg_file`. It generalises data width, depth and read-port count. It adds a self-clearing sweep after reset or on request, a `ready` indication, and an optional write-to-read bypass. It sits in the datapath between decode (read addresses) and writeback (`RegWrite`, `write_register`, `data_in`).

---
 rtl/reg_file_mp_pkg.sv | 14 +
 rtl/reg_file_mp_clear_ctrl.sv | 63 ++++++
 rtl/reg_file_mp.sv | 70 +++++++
 tb/tb_reg_file_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Pure definitions: no logic, no latency, no flow control.
package reg_file_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/reg_file_mp_clear_ctrl.sv
// Sweep controller: zeroes one entry per cycle after reset or clear_req, then flags READY.
// Sweep takes 2**ADDR_W edges; ready is registered; no backpressure (requests during a sweep are ignored).
module reg_file_mp_clear_ctrl
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_stb,
    output state_t            state,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= (state_nxt == READY);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_stb   = 1'b0;
        case (state)
            CLEAR: begin
                // Reset held low must not let the sweep advance or write.
                clr_stb = rst_n;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Register file, NUM_RD combinational read ports, one write port, self-clearing sweep; macro REG_FILE_MP_BYPASS_EN adds write-to-read forwarding.
// Writes land at the edge (reads see them next cycle, or same cycle with bypass); no backpressure, writes while ready=0 are dropped.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] raddr [NUM_RD],
    output logic [DATA_W-1:0] data_out [NUM_RD],
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_stb;
    logic              wr_en;
    state_t            state;

    reg_file_mp_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .clr_addr  (clr_addr),
        .clr_stb   (clr_stb),
        .state     (state),
        .ready     (ready)
    );

    // A clear request in the same cycle wins over the write.
    assign wr_en = (state == READY) && rst_n && RegWrite && !clear_req;

    always_ff @(posedge clk) begin
        if (clr_stb) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[write_register] <= data_in;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [DATA_W-1:0] rd_dat;

        always_comb begin
            rd_dat = '0;
            if (state == READY) begin
                rd_dat = mem[raddr[g]];
`ifdef REG_FILE_MP_BYPASS_EN
                if (RegWrite && (raddr[g] == write_register)) begin
                    rd_dat = data_in;
                end
`endif
            end
        end

        assign data_out[g] = rd_dat;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed table, multi-cycle sequences, randomized run vs. reference model.
module tb_reg_file_mp;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RegWrite;
    logic [3:0] write_register;
    logic [7:0] data_in;
    logic       clear_req;
    logic [3:0] raddr [2];
    logic [7:0] data_out [2];
    logic       ready;

    int total = 0;
    int bad   = 0;

    // Reference model: contents, ready flag, and edges left in the current sweep.
    logic [7:0] m_mem [16];
    bit         m_ready;
    int         m_left;

    typedef struct {
        bit         rw;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic [7:0] e_d0;
        logic [7:0] e_d1;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .data_in        (data_in),
        .clear_req      (clear_req),
        .raddr          (raddr),
        .data_out       (data_out),
        .ready          (ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        if (!m_ready) return 8'd0;
        if (BYP && RegWrite && a == write_register) return data_in;
        return m_mem[a];
    endfunction

    // Checks the current cycle against the model, then advances one edge.
    task automatic cycle();
        #1;
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("data_out0", {24'd0, data_out[0]}, {24'd0, exp_rd(raddr[0])});
        chk("data_out1", {24'd0, data_out[1]}, {24'd0, exp_rd(raddr[1])});
        @(posedge clk);
        if (!rst_n) begin
            m_ready = 1'b0;
            m_left  = 16;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;
            end
        end else if (clear_req) begin
            m_ready = 1'b0;
            m_left  = 16;
        end else if (RegWrite) begin
            m_mem[write_register] = data_in;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        RegWrite = 1'b0; write_register = 4'd0; data_in = 8'd0; clear_req = 1'b0;
        raddr[0] = 4'd0; raddr[1] = 4'd0;
    endtask

    // Runs idle-ish cycles until ready rises; returns the number of edges taken.
    task automatic wait_ready(input bit try_writes, output int n);
        n = 0;
        while (!ready && n < 40) begin
            RegWrite       = try_writes;
            write_register = 4'd4;
            data_in        = 8'd99;
            raddr[0]       = 4'd4;
            raddr[1]       = 4'($urandom_range(15));
            cycle();
            n++;
        end
        idle();
    endtask

    task automatic read_zero(input string nm, input logic [3:0] a0, input logic [3:0] a1);
        idle();
        raddr[0] = a0; raddr[1] = a1;
        #1;
        chk({nm, "_p0"}, {24'd0, data_out[0]}, 32'd0);
        chk({nm, "_p1"}, {24'd0, data_out[1]}, 32'd0);
        cycle();
    endtask

    initial begin
        int n;
        vt[0] = '{1'b1, 4'd14, 8'd255, 4'd14, 4'd0,  (BYP ? 8'd255 : 8'd0), 8'd0};
        vt[1] = '{1'b1, 4'd9,  8'd200, 4'd14, 4'd9,  8'd255, (BYP ? 8'd200 : 8'd0)};
        vt[2] = '{1'b0, 4'd3,  8'd155, 4'd3,  4'd9,  8'd0,   8'd200};
        vt[3] = '{1'b0, 4'd3,  8'd155, 4'd3,  4'd14, 8'd0,   8'd255};
        vt[4] = '{1'b1, 4'd5,  8'hA5,  4'd5,  4'd5,  (BYP ? 8'hA5 : 8'd0), (BYP ? 8'hA5 : 8'd0)};
        vt[5] = '{1'b0, 4'd5,  8'd0,   4'd5,  4'd15, 8'hA5,  8'd0};
        vt[6] = '{1'b1, 4'd15, 8'h3C,  4'd0,  4'd15, 8'd0,   (BYP ? 8'h3C : 8'd0)};
        vt[7] = '{1'b0, 4'd0,  8'd0,   4'd15, 4'd0,  8'h3C,  8'd0};

        rst_n = 1'b0;
        idle();
        @(negedge clk);
        m_ready = 1'b0;
        m_left  = 16;
        cycle();
        cycle();

        // Reset release: sweep latency, then every entry reads zero.
        rst_n = 1'b1;
        wait_ready(1'b0, n);
        chk("rst_ready_latency", n, 16);
        for (int a = 0; a < 16; a++) begin
            raddr[0] = 4'(a);
            raddr[1] = 4'(15 - a);
            cycle();
        end

        for (int i = 0; i < 8; i++) begin
            RegWrite = vt[i].rw; write_register = vt[i].wa; data_in = vt[i].wd;
            clear_req = 1'b0; raddr[0] = vt[i].ra0; raddr[1] = vt[i].ra1;
            #1;
            chk($sformatf("vec%0d_p0", i), {24'd0, data_out[0]}, {24'd0, vt[i].e_d0});
            chk($sformatf("vec%0d_p1", i), {24'd0, data_out[1]}, {24'd0, vt[i].e_d1});
            cycle();
        end

        // Clear request racing a write: clear wins, full sweep follows.
        RegWrite = 1'b1; write_register = 4'd2; data_in = 8'd77; clear_req = 1'b1;
        raddr[0] = 4'd2; raddr[1] = 4'd9;
        cycle();
        idle();
        chk("clear_ready_low", {31'd0, ready}, 32'd0);
        wait_ready(1'b1, n);
        chk("clear_ready_latency", n, 16);
        read_zero("after_clear_a", 4'd2, 4'd9);
        read_zero("after_clear_b", 4'd14, 4'd4);

        // Reset in the middle of a sweep restarts it from entry 0.
        clear_req = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 7; i++) begin
            RegWrite = 1'b1; write_register = 4'd4; data_in = 8'd99;
            cycle();
        end
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_ready(1'b1, n);
        chk("midsweep_ready_latency", n, 16);
        read_zero("midsweep_write_dropped", 4'd4, 4'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n          = ($urandom_range(199) != 0);
            clear_req      = ($urandom_range(39) == 0);
            RegWrite       = 1'($urandom_range(1));
            write_register = 4'($urandom_range(15));
            data_in        = 8'($urandom_range(255));
            raddr[0]       = ($urandom_range(3) == 0) ? write_register : 4'($urandom_range(15));
            raddr[1]       = ($urandom_range(3) == 0) ? raddr[0] : 4'($urandom_range(15));
            cycle();
        end
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
